// File: rtl/cska_pkg.sv
// Shared helpers and types for the pipelined carry-skip adder.
package cska_pkg;

  // Number of skip blocks (and block pipeline stages) for a given width.
  // A degenerate BLOCK yields 1 so that elaboration reaches the
  // parameter check instead of dividing by zero.
  function automatic int nblk(input int width, input int block);
    return (block < 1) ? 1 : width / block;
  endfunction

  // Control part of every stage payload; operand and sum fields are
  // width-dependent and are attached by the top module.
  typedef struct packed {
    logic valid;
    logic carry;
  } stage_ctrl_t;

endpackage

// File: rtl/cska_block.sv
// One carry-skip block: BLOCK-bit ripple chain plus the bypass mux that
// forwards the block carry-in when every propagate bit is set.
module cska_block #(
  parameter int BLOCK = 4
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             cin,
  output logic [BLOCK-1:0] sum,
  output logic             cout,
  output logic             p_all
);

  logic [BLOCK-1:0] prop;
  logic [BLOCK:0]   carry;

  // Ripple the carry through the block, then choose bypass or ripple carry.
  always_comb begin
    prop     = a ^ b;
    carry    = '0;
    carry[0] = cin;
    for (int i = 0; i < BLOCK; i++) begin
      carry[i+1] = (a[i] & b[i]) | (prop[i] & carry[i]);
    end
    sum   = prop ^ carry[BLOCK-1:0];
    p_all = &prop;
    // With all propagates set the ripple carry equals cin, so the bypass
    // only shortens the path and never changes the value.
    cout  = p_all ? cin : carry[BLOCK];
  end

endmodule

// File: rtl/pipelined_carry_skip_adder.sv
// Pipelined carry-skip adder: stage 0 captures the operands, then one
// carry-skip block per stage fills in the sum from LSB to MSB. The whole
// pipe advances together under a single valid/ready handshake.
module pipelined_carry_skip_adder
  import cska_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int BLOCK = 4,
  localparam int NBLK  = nblk(WIDTH, BLOCK)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             c_out,
  output logic             ovf,
  output logic [NBLK-1:0]  skip
);

  generate
    if (BLOCK < 1) begin : g_bad_block
      $error("pipelined_carry_skip_adder: BLOCK must be >= 1");
    end else if (WIDTH % BLOCK != 0) begin : g_bad_width
      $error("pipelined_carry_skip_adder: WIDTH must be a multiple of BLOCK");
    end
  endgenerate

  typedef struct packed {
    stage_ctrl_t      ctrl;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] s_partial;
    logic [NBLK-1:0]  skip;
  } payload_t;

  // Signed overflow: operands agree in sign but the sum does not.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb,
                                      input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

  // Stage 0 holds raw operands; stage k+1 holds the result of block k.
  payload_t stage_p [0:NBLK];
  payload_t next_p  [0:NBLK];

  logic [BLOCK-1:0] blk_sum  [NBLK];
  logic             blk_cout [NBLK];
  logic             blk_pall [NBLK];

  logic run;
  logic adv;

  genvar k;
  generate
    for (k = 0; k < NBLK; k++) begin : g_blk
      cska_block #(.BLOCK(BLOCK)) u_blk (
        .a     (stage_p[k].a[k*BLOCK +: BLOCK]),
        .b     (stage_p[k].b[k*BLOCK +: BLOCK]),
        .cin   (stage_p[k].ctrl.carry),
        .sum   (blk_sum[k]),
        .cout  (blk_cout[k]),
        .p_all (blk_pall[k])
      );
    end
  endgenerate

  assign out_valid = stage_p[NBLK].ctrl.valid;
  // The pipe moves only once reset has been released for a clock, and
  // never while the output holds an unconsumed result.
  assign adv       = run & (~out_valid | out_ready);
  assign in_ready  = adv;

  assign s     = stage_p[NBLK].s_partial;
  assign c_out = stage_p[NBLK].ctrl.carry;
  assign skip  = stage_p[NBLK].skip;
  assign ovf   = signed_ovf(stage_p[NBLK].a[WIDTH-1], stage_p[NBLK].b[WIDTH-1],
                            stage_p[NBLK].s_partial[WIDTH-1]);

  // Build each stage's next payload: operand capture, then block k merged
  // into the payload travelling out of stage k.
  always_comb begin
    next_p[0].ctrl.valid = in_valid;
    next_p[0].ctrl.carry = c_in;
    next_p[0].a          = a;
    next_p[0].b          = b;
    next_p[0].s_partial  = '0;
    next_p[0].skip       = '0;
    for (int i = 0; i < NBLK; i++) begin
      next_p[i+1]                             = stage_p[i];
      next_p[i+1].s_partial[i*BLOCK +: BLOCK] = blk_sum[i];
      next_p[i+1].ctrl.carry                  = blk_cout[i];
      next_p[i+1].skip[i]                     = blk_pall[i];
    end
  end

  // Reset release is taken in synchronously before the pipe may advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run <= 1'b0;
    end else begin
      run <= 1'b1;
    end
  end

  // Stage registers: flushed on reset, shifted as a whole on advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= NBLK; i++) begin
        stage_p[i] <= '0;
      end
    end else if (adv) begin
      for (int i = 0; i <= NBLK; i++) begin
        stage_p[i] <= next_p[i];
      end
    end
  end

endmodule

// File: tb/tb_pipelined_carry_skip_adder.sv
// Directed and randomised bench for the pipelined carry-skip adder
// (WIDTH=16, BLOCK=4, four block stages, result four clocks after accept).
module tb_pipelined_carry_skip_adder;

  localparam int W  = 16;
  localparam int NB = 4;
  localparam int NRAND = 10000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          c_in;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  s;
  logic          c_out;
  logic          ovf;
  logic [NB-1:0] skip;

  int n_checks = 0;
  int n_fail   = 0;

  pipelined_carry_skip_adder #(.WIDTH(W), .BLOCK(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .c_out     (c_out),
    .ovf       (ovf),
    .skip      (skip)
  );

  always #5 clk = ~clk;

  // Reference result packed as {s, c_out, ovf, skip}.
  function automatic logic [21:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                        input logic ci);
    logic [W:0]    sum;
    logic          ov;
    logic [NB-1:0] sk;
    logic [W-1:0]  px;
    sum = {1'b0, x} + {1'b0, y} + {16'd0, ci};
    ov  = (x[W-1] == y[W-1]) && (sum[W-1] != x[W-1]);
    px  = x ^ y;
    for (int k = 0; k < NB; k++) sk[k] = &px[k*4 +: 4];
    return {sum[W-1:0], sum[W], ov, sk};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; c_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({out_valid, s, c_out, ovf, skip} !== 23'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: out_valid=%b s=%h c_out=%b ovf=%b skip=%b, required all zero",
               out_valid, s, c_out, ovf, skip);
    end
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b, required 0 while in reset", in_ready);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL release_in_ready: got %b, required 1 after first clock", in_ready);
    end
  endtask

  task automatic test_directed();
    logic [W-1:0]  va [5] = '{16'hFFFF, 16'h7FFF, 16'hAAAA, 16'h8000, 16'h0F0F};
    logic [W-1:0]  vb [5] = '{16'h0001, 16'h0001, 16'h5555, 16'h8000, 16'hF0F0};
    logic          vc [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    // {s, c_out, ovf, skip} worked out by hand
    logic [21:0]   ve [5] = '{{16'h0000, 1'b1, 1'b0, 4'b1110},
                              {16'h8000, 1'b0, 1'b1, 4'b0110},
                              {16'h0000, 1'b1, 1'b0, 4'b1111},
                              {16'h0000, 1'b1, 1'b1, 4'b0000},
                              {16'hFFFF, 1'b0, 1'b0, 4'b1111}};
    logic rdy;
    int   cyc;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      a = va[i]; b = vb[i]; c_in = vc[i]; in_valid = 1'b1; out_ready = 1'b1;
      rdy = in_ready;
      @(posedge clk); #1;
      in_valid = 1'b0;
      n_checks++;
      if (rdy !== 1'b1) begin
        n_fail++;
        $display("FAIL directed_accept[%0d]: in_ready=%b, required 1", i, rdy);
      end
      cyc = 0;
      while (out_valid !== 1'b1 && cyc < 20) begin
        @(posedge clk); #1; cyc++;
      end
      n_checks++;
      if (cyc !== 4) begin
        n_fail++;
        $display("FAIL directed_latency[%0d]: got %0d cycles, required 4", i, cyc);
      end
      n_checks++;
      if ({s, c_out, ovf, skip} !== ve[i]) begin
        n_fail++;
        $display("FAIL directed_result[%0d]: s=%h c_out=%b ovf=%b skip=%b, required s=%h c_out=%b ovf=%b skip=%b",
                 i, s, c_out, ovf, skip, ve[i][21:6], ve[i][5], ve[i][4], ve[i][3:0]);
      end
      @(posedge clk); #1;
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL directed_drain[%0d]: out_valid=%b, required 0", i, out_valid);
      end
    end
  endtask

  task automatic test_back_to_back_stall();
    logic [21:0] exp_q[$];
    logic [21:0] hold;
    logic [21:0] want;
    logic [W-1:0] xa, xb;
    logic xc, acc;
    int i, guard, cyc, got;
    out_ready = 1'b1;
    fork
      begin : producer
        i = 0; guard = 0;
        while (i < 6 && guard < 100) begin
          @(negedge clk);
          xa = 16'h1111 * 16'(i + 1); xb = 16'h0F0F + 16'(i); xc = 1'(i & 1);
          a = xa; b = xb; c_in = xc; in_valid = 1'b1;
          acc = in_ready;
          if (acc) exp_q.push_back(model(xa, xb, xc));
          @(posedge clk);
          if (acc) i++;
          guard++;
        end
        @(negedge clk); in_valid = 1'b0;
      end
      begin : consumer
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 40) begin
          @(posedge clk); #1; cyc++;
        end
        n_checks++;
        if (out_valid !== 1'b1) begin
          n_fail++;
          $display("FAIL stall_first_valid: out_valid=%b after %0d cycles, required 1", out_valid, cyc);
        end
        out_ready = 1'b0;
        hold = {s, c_out, ovf, skip};
        repeat (5) begin
          @(posedge clk); #1;
          n_checks++;
          if (out_valid !== 1'b1 || in_ready !== 1'b0 || {s, c_out, ovf, skip} !== hold) begin
            n_fail++;
            $display("FAIL stall_hold: out_valid=%b in_ready=%b result=%h, required 1 0 %h",
                     out_valid, in_ready, {s, c_out, ovf, skip}, hold);
          end
        end
        out_ready = 1'b1;
        got = 0; cyc = 0;
        while (got < 6 && cyc < 60) begin
          @(negedge clk);
          if (out_valid === 1'b1) begin
            want = (exp_q.size() > 0) ? exp_q.pop_front() : 22'h3FFFFF;
            n_checks++;
            if ({s, c_out, ovf, skip} !== want) begin
              n_fail++;
              $display("FAIL stall_order[%0d]: got %h, required %h", got, {s, c_out, ovf, skip}, want);
            end
            got++;
          end
          @(posedge clk);
          cyc++;
        end
        n_checks++;
        if (got !== 6) begin
          n_fail++;
          $display("FAIL stall_count: got %0d results, required 6", got);
        end
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL stall_no_dup: out_valid=%b after drain, required 0", out_valid);
        end
      end
    join
  endtask

  task automatic test_reset_midstream();
    int  cyc;
    logic seen;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a = 16'h0100 * 16'(i + 1); b = 16'h0011; c_in = 1'b0; in_valid = 1'b1;
    end
    @(negedge clk); in_valid = 1'b0;
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 20) begin
      @(posedge clk); #1; cyc++;
    end
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_prefill: out_valid=%b, required 1 before reset", out_valid);
    end
    @(negedge clk); rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || s !== 16'h0000) begin
      n_fail++;
      $display("FAIL midreset_flush: out_valid=%b s=%h, required 0 0000", out_valid, s);
    end
    @(negedge clk); rst_n = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_no_results: a flushed result reappeared (seen=%b), required 0", seen);
    end
  endtask

  task automatic test_random();
    logic [21:0] exp_q[$];
    logic [21:0] want;
    logic [W-1:0] xa, xb;
    logic xc;
    int sent, got, pcyc, ccyc, bad;
    sent = 0; got = 0; bad = 0;
    fork
      begin : rproducer
        pcyc = 0;
        while (sent < NRAND && pcyc < 40000) begin
          @(negedge clk);
          xa = 16'($urandom); xb = 16'($urandom); xc = 1'($urandom_range(1));
          a = xa; b = xb; c_in = xc;
          in_valid = ($urandom_range(3) != 0);
          if (in_valid && in_ready) begin
            exp_q.push_back(model(xa, xb, xc));
            sent++;
          end
          @(posedge clk);
          pcyc++;
        end
        @(negedge clk); in_valid = 1'b0;
      end
      begin : rconsumer
        ccyc = 0;
        while (got < NRAND && ccyc < 40200) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(3) != 0);
          ccyc++;
          @(negedge clk);
          if (out_valid === 1'b1 && out_ready) begin
            want = (exp_q.size() > 0) ? exp_q.pop_front() : 22'h3FFFFF;
            n_checks++;
            if ({s, c_out, ovf, skip} !== want) begin
              n_fail++;
              if (bad < 10)
                $display("FAIL random[%0d]: s=%h c_out=%b ovf=%b skip=%b, required s=%h c_out=%b ovf=%b skip=%b",
                         got, s, c_out, ovf, skip, want[21:6], want[5], want[4], want[3:0]);
              bad++;
            end
            got++;
          end
        end
      end
    join
    out_ready = 1'b1;
    n_checks++;
    if (got !== NRAND || sent !== NRAND) begin
      n_fail++;
      $display("FAIL random_count: sent=%0d received=%0d, required %0d each", sent, got, NRAND);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back_stall();
    test_reset_midstream();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
